// File: rtl/latch_bus_arbiter.sv
// Round-robin arbiter that hands one tri-state latch enable out at a time,
// with a mandatory all-low turnaround cycle between consecutive grants.
module latch_bus_arbiter #(
   parameter int N_REQ = 4,
   parameter int HOLD  = 4,
   localparam int GW   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int CW   = $clog2(HOLD + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] done,
   output logic [N_REQ-1:0] enable,
   output logic [GW-1:0]    grant_id,
   output logic             busy,
   output logic [1:0]       state_o
);

   // Handshake: req[i] is a level held while requester i wants the bus; the
   // grant is visible as enable[i]. The grantee releases early by pulsing
   // done[i] or dropping req[i]; both are sampled only for the current grantee.

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } state_t;

   state_t           state_q;
   logic [N_REQ-1:0] enable_q;
   logic [GW-1:0]    grant_q;
   logic [GW-1:0]    last_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;

   logic             sel_found;
   logic [GW-1:0]    sel_idx;
   logic [N_REQ-1:0] enable_d;
   logic             grant_end;
   int               idx;

   // Search upward from last+1, wrapping, so the previous grantee is tried last.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      idx       = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = int'(last_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!sel_found && req[GW'(idx)]) begin
            sel_found = 1'b1;
            sel_idx   = GW'(idx);
         end
      end
   end

   assign enable_d  = N_REQ'(1) << sel_idx;
   assign grant_end = done[grant_q] || !req[grant_q] || (cnt_q == CW'(HOLD));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         enable_q <= '0;
         grant_q  <= '0;
         last_q   <= GW'(N_REQ - 1);
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_TURN: begin
               if (sel_found) begin
                  state_q  <= ST_GRANT;
                  enable_q <= enable_d;
                  grant_q  <= sel_idx;
                  last_q   <= sel_idx;
                  cnt_q    <= CW'(1);
                  busy_q   <= 1'b1;
               end else begin
                  state_q  <= ST_IDLE;
                  enable_q <= '0;
                  busy_q   <= 1'b0;
               end
            end
            ST_GRANT: begin
               if (grant_end) begin
                  state_q  <= ST_TURN;
                  enable_q <= '0;
                  busy_q   <= 1'b0;
               end else begin
                  cnt_q    <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               enable_q <= '0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign enable   = enable_q;
   assign grant_id = grant_q;
   assign busy     = busy_q;
   assign state_o  = state_q;

endmodule

// File: tb/tb_latch_bus_arbiter.sv
// Bench for latch_bus_arbiter: directed vector tables for the corner cases,
// randomized traffic against a grant-level reference model, and bus invariants.
module tb_latch_bus_arbiter;

   localparam int N    = 4;
   localparam int HOLD = 4;

   logic       clk;
   logic       rst_m, rst_h;
   logic [3:0] req_m, done_m, req_h, done_h;
   logic [3:0] en_m, en_h;
   logic [1:0] gid_m, gid_h, st_m, st_h;
   logic       busy_m, busy_h;

   int checks = 0;
   int errors = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   latch_bus_arbiter #(.N_REQ(N), .HOLD(HOLD)) dut_m (
      .clk(clk), .reset(rst_m), .req(req_m), .done(done_m),
      .enable(en_m), .grant_id(gid_m), .busy(busy_m), .state_o(st_m)
   );

   latch_bus_arbiter #(.N_REQ(N), .HOLD(1)) dut_h (
      .clk(clk), .reset(rst_h), .req(req_h), .done(done_h),
      .enable(en_h), .grant_id(gid_h), .busy(busy_h), .state_o(st_h)
   );

   // ---------------- driver / checker tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---------------- bus invariants ----------------
   logic [3:0] prev_m = '0, prev_h = '0;

   always @(negedge clk) begin
      check("onehot_m", {31'd0, $onehot0(en_m)}, 32'd1);
      check("busy_or_m", {31'd0, busy_m}, {31'd0, |en_m});
      check("gap_m", {31'd0, (prev_m != 0 && en_m != 0 && prev_m != en_m)}, 32'd0);
      check("onehot_h", {31'd0, $onehot0(en_h)}, 32'd1);
      check("gap_h", {31'd0, (prev_h != 0 && en_h != 0 && prev_h != en_h)}, 32'd0);
      prev_m = en_m;
      prev_h = en_h;
   end

   // ---------------- reference model ----------------
   // Tracks who owns the bus and for how long; an ended grant leaves the bus
   // unowned for one edge before the next round-robin pick.
   int m_owner, m_len, m_last, m_gid;

   task automatic model_pick(input logic [3:0] rq);
      for (int k = 1; k <= N; k++) begin
         int i = (m_last + k) % N;
         if (rq[i[1:0]]) begin
            m_owner = i;
            m_len   = 1;
            m_last  = i;
            m_gid   = i;
            return;
         end
      end
   endtask

   task automatic model_step(input bit rst, input logic [3:0] rq, input logic [3:0] dn);
      if (rst) begin
         m_owner = -1;
         m_len   = 0;
         m_last  = N - 1;
         m_gid   = 0;
      end else if (m_owner >= 0) begin
         if (dn[m_owner[1:0]] || !rq[m_owner[1:0]] || m_len == HOLD) m_owner = -1;
         else m_len++;
      end else begin
         model_pick(rq);
      end
   endtask

   function automatic logic [6:0] model_out();
      logic [3:0] one = 4'b0001;
      logic [3:0] en  = (m_owner >= 0) ? (one << m_owner) : 4'b0000;
      return {en, m_gid[1:0], (m_owner >= 0)};
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      bit         h1;
      bit         rst;
      logic [3:0] rq;
      logic [3:0] dn;
      logic [3:0] en;
      logic [1:0] gid;
      bit         busy;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(bit h1, bit rst, logic [3:0] rq, logic [3:0] dn,
                               logic [3:0] en, logic [1:0] gid, bit busy);
      tbl.push_back('{h1, rst, rq, dn, en, gid, busy});
   endfunction

   logic [6:0] exp_q[$];

   initial begin
      logic [6:0] got, exp;
      logic [3:0] rq;
      bit         rs;

      rst_m = 1; req_m = '0; done_m = '0;
      rst_h = 1; req_h = '0; done_h = '0;

      // Reset and first grant, then a full all-requesting rotation.
      add(0, 1, 4'b1111, 0, 4'b0000, 0, 0);
      add(0, 1, 4'b1111, 0, 4'b0000, 0, 0);
      for (int g = 0; g < 5; g++) begin
         for (int c = 0; c < 4; c++) add(0, 0, 4'b1111, 0, 4'b0001 << (g % 4), 2'(g % 4), 1);
         if (g < 4) add(0, 0, 4'b1111, 0, 4'b0000, 2'(g % 4), 0);
      end
      // Early release by done in the 2nd grant cycle, then wrap re-grant.
      add(0, 1, 4'b0100, 0,       4'b0000, 0, 0);
      add(0, 0, 4'b0100, 0,       4'b0100, 2, 1);
      add(0, 0, 4'b0100, 0,       4'b0100, 2, 1);
      add(0, 0, 4'b0100, 4'b0100, 4'b0000, 2, 0);
      add(0, 0, 4'b0100, 0,       4'b0100, 2, 1);
      add(0, 0, 4'b0100, 0,       4'b0100, 2, 1);
      // Non-grantee done noise, then request drop.
      add(0, 1, 4'b0010, 0,       4'b0000, 0, 0);
      add(0, 0, 4'b0010, 0,       4'b0010, 1, 1);
      add(0, 0, 4'b0010, 4'b1001, 4'b0010, 1, 1);
      add(0, 0, 4'b0010, 0,       4'b0010, 1, 1);
      add(0, 0, 4'b0000, 0,       4'b0000, 1, 0);
      add(0, 0, 4'b0000, 0,       4'b0000, 1, 0);
      add(0, 0, 4'b0000, 0,       4'b0000, 1, 0);
      // Reset mid-grant, then a fresh full-length grant.
      add(0, 1, 4'b0010, 0, 4'b0000, 0, 0);
      add(0, 0, 4'b0010, 0, 4'b0010, 1, 1);
      add(0, 0, 4'b0010, 0, 4'b0010, 1, 1);
      add(0, 1, 4'b0010, 0, 4'b0000, 0, 0);
      for (int c = 0; c < 4; c++) add(0, 0, 4'b0010, 0, 4'b0010, 1, 1);
      add(0, 0, 4'b0010, 0, 4'b0000, 1, 0);
      // HOLD=1 instance: single-cycle grants separated by turnaround.
      add(1, 1, 4'b0011, 0, 4'b0000, 0, 0);
      for (int g = 0; g < 3; g++) begin
         add(1, 0, 4'b0011, 0, 4'b0001 << (g % 2), 2'(g % 2), 1);
         add(1, 0, 4'b0011, 0, 4'b0000, 2'(g % 2), 0);
      end

      foreach (tbl[i]) begin
         if (tbl[i].h1) begin
            rst_h = tbl[i].rst; req_h = tbl[i].rq; done_h = tbl[i].dn;
            rst_m = 1; req_m = '0; done_m = '0;
         end else begin
            rst_m = tbl[i].rst; req_m = tbl[i].rq; done_m = tbl[i].dn;
            rst_h = 1; req_h = '0; done_h = '0;
         end
         step();
         if (tbl[i].h1) got = {en_h, gid_h, busy_h};
         else           got = {en_m, gid_m, busy_m};
         check($sformatf("vec%0d_en", i),   {28'd0, got[6:3]}, {28'd0, tbl[i].en});
         check($sformatf("vec%0d_gid", i),  {30'd0, got[2:1]}, {30'd0, tbl[i].gid});
         check($sformatf("vec%0d_busy", i), {31'd0, got[0]},   {31'd0, tbl[i].busy});
      end

      // Randomized traffic against the model.
      rst_h = 1; req_h = '0; done_h = '0;
      rq = '0;
      for (int n = 0; n < 600; n++) begin
         rs = (n == 0) || ($urandom_range(0, 149) == 0);
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
         rst_m  = rs;
         req_m  = rq;
         done_m = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         model_step(rs, req_m, done_m);
         exp_q.push_back(model_out());
         step();
         got = {en_m, gid_m, busy_m};
         exp = exp_q.pop_front();
         check($sformatf("rand%0d", n), {25'd0, got}, {25'd0, exp});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
